// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, register file with writeback bypass,
// per-register write scoreboard and a one-entry valid/ready output register.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SB_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_rs1_val_o,
  output logic [XLEN-1:0] id_rs2_val_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [2:0]      id_imm_type_o,
  output logic [4:0]      id_rd_o,
  output logic            id_rd_we_o,
  output logic            id_illegal_o
);

  localparam int unsigned NREGS = 32;
  localparam logic [SB_W:0] SB_MAX = (SB_W+1)'((1 << SB_W) - 1);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_U = 3'd2, IMM_S = 3'd3,
    IMM_B = 3'd4, IMM_J = 3'd5, IMM_ILL = 3'd7
  } imm_type_e;

  logic [XLEN-1:0] rf [NREGS];
  logic [SB_W-1:0] cnt [NREGS];

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opcode = if_instr_i[6:0];
  assign rd_f   = if_instr_i[11:7];
  assign f3     = if_instr_i[14:12];
  assign rs1_f  = if_instr_i[19:15];
  assign rs2_f  = if_instr_i[24:20];
  assign f7     = if_instr_i[31:25];

  imm_type_e       dec_type;
  logic            dec_ill, use_rs1, use_rs2, dec_wr, dec_rd_we;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm, rs1_val, rs2_val;

  always_comb begin
    dec_type = IMM_ILL;
    dec_ill  = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    dec_wr   = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin dec_type = IMM_U; dec_ill = 1'b0; dec_wr = 1'b1; end
      7'b1101111: begin dec_type = IMM_J; dec_ill = 1'b0; dec_wr = 1'b1; end
      7'b1100111: if (f3 == 3'b000) begin
        dec_type = IMM_I; dec_ill = 1'b0; use_rs1 = 1'b1; dec_wr = 1'b1;
      end
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
        dec_type = IMM_B; dec_ill = 1'b0; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
        dec_type = IMM_I; dec_ill = 1'b0; use_rs1 = 1'b1; dec_wr = 1'b1;
      end
      7'b0100011: if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
        dec_type = IMM_S; dec_ill = 1'b0; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0010011: if ((f3 != 3'b001 && f3 != 3'b101) || (f7 == 7'b0000000) ||
                      (f3 == 3'b101 && f7 == 7'b0100000)) begin
        dec_type = IMM_I; dec_ill = 1'b0; use_rs1 = 1'b1; dec_wr = 1'b1;
      end
      7'b0110011: if (f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
        dec_type = IMM_NONE; dec_ill = 1'b0; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wr = 1'b1;
      end
      7'b0001111: if (f3 == 3'b000) begin dec_type = IMM_NONE; dec_ill = 1'b0; end
      7'b1110011: if (f3 == 3'b000 && rd_f == 5'd0 && rs1_f == 5'd0 &&
                      (if_instr_i[31:20] == 12'h000 || if_instr_i[31:20] == 12'h001)) begin
        dec_type = IMM_NONE; dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  assign dec_rd_we = dec_wr && (rd_f != 5'd0);

  always_comb begin
    case (dec_type)
      IMM_I:   imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      IMM_U:   imm32 = {if_instr_i[31:12], 12'b0};
      IMM_S:   imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      IMM_B:   imm32 = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                        if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      IMM_J:   imm32 = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                        if_instr_i[20], if_instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end
  assign dec_imm = XLEN'(signed'(imm32));

  // Same-cycle writeback data wins over the stored register value.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_f != 5'd0) rs1_val = (wb_en_i && wb_rd_i == rs1_f) ? wb_data_i : rf[rs1_f];
    if (rs2_f != 5'd0) rs2_val = (wb_en_i && wb_rd_i == rs2_f) ? wb_data_i : rf[rs2_f];
  end

  logic hazard, sat, busy1, busy2, pend, hs, accept;
  logic [SB_W:0] rd_load;

  always_comb begin
    busy1 = (rs1_f != 5'd0) &&
            ((cnt[rs1_f] > SB_W'(wb_en_i && wb_rd_i == rs1_f)) ||
             (id_valid_o && id_rd_we_o && id_rd_o == rs1_f));
    busy2 = (rs2_f != 5'd0) &&
            ((cnt[rs2_f] > SB_W'(wb_en_i && wb_rd_i == rs2_f)) ||
             (id_valid_o && id_rd_we_o && id_rd_o == rs2_f));
    hazard = (use_rs1 && busy1) || (use_rs2 && busy2);
    // The producer still in the output register is counted so cnt can never wrap.
    pend    = id_valid_o && id_rd_we_o && (id_rd_o == rd_f);
    rd_load = {1'b0, cnt[rd_f]} + (SB_W+1)'(pend);
    sat     = dec_rd_we && (rd_load >= SB_MAX);
  end

  assign if_ready_o = !hazard && !sat && (!id_valid_o || id_ready_i) && !flush_i;
  assign accept     = if_valid_i && if_ready_o;
  assign hs         = id_valid_o && id_ready_i && id_rd_we_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_o    <= 1'b0;
      id_pc_o       <= '0;
      id_rs1_val_o  <= '0;
      id_rs2_val_o  <= '0;
      id_imm_o      <= '0;
      id_imm_type_o <= '0;
      id_rd_o       <= '0;
      id_rd_we_o    <= 1'b0;
      id_illegal_o  <= 1'b0;
    end else begin
      if (flush_i)         id_valid_o <= 1'b0;
      else if (accept)     id_valid_o <= 1'b1;
      else if (id_ready_i) id_valid_o <= 1'b0;
      if (accept) begin
        id_pc_o       <= if_pc_i;
        id_rs1_val_o  <= rs1_val;
        id_rs2_val_o  <= rs2_val;
        id_imm_o      <= dec_imm;
        id_imm_type_o <= dec_type;
        id_rd_o       <= rd_f;
        id_rd_we_o    <= dec_rd_we;
        id_illegal_o  <= dec_ill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en_i && wb_rd_i != 5'd0) begin
      rf[wb_rd_i] <= wb_data_i;
    end
  end

  logic [NREGS-1:0] sb_inc, sb_dec;
  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    if (hs)      sb_inc[id_rd_o] = 1'b1;
    if (wb_en_i) sb_dec[wb_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (sb_inc[i] && !sb_dec[i])                        cnt[i] <= cnt[i] + 1'b1;
        else if (sb_dec[i] && !sb_inc[i] && cnt[i] != '0)   cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RISC-V RV32I decode stage. It sits between fetch and execute and owns the integer register file. It extends the combinational decoder with several features:
- a valid/ready handshake and a one-entry output register;
- a per-register scoreboard that stalls read-after-write hazards;
- same-cycle writeback bypass;
- parametrised data width and outstanding-write depth.

## Interface
Parameters:
- XLEN, 32: register/data/PC width.
- SB_W, 2: width of each scoreboard counter; max outstanding writes per register = 2^SB_W-1.

Ports:
- Clocking and reset:
  - clk  in  1  clock, rising edge.
  - rst  in  1  reset, asynchronous, active-high.
- Fetch side:
  - if_valid_i  in  1  fetch holds an instruction.
  - if_ready_o  out  1  decode accepts this cycle (combinational).
  - if_instr_i  in  32  instruction word.
  - if_pc_i  in  XLEN  its PC.
- Control and writeback:
  - flush_i  in  1  kill instruction held in output register.
  - wb_en_i  in  1  writeback strobe.
  - wb_rd_i  in  5  writeback register.
  - wb_data_i  in  XLEN  writeback data.
- Execute side:
  - id_valid_o  out  1  output register valid.
  - id_ready_i  in  1  execute accepts.
  - id_pc_o  out  XLEN  PC.
  - id_rs1_val_o, id_rs2_val_o  out  XLEN  operand values.
  - id_imm_o  out  XLEN  sign-extended immediate.
  - id_imm_type_o  out  3  0 none, 1 I, 2 U, 3 S, 4 B, 5 J, 7 illegal.
  - id_rd_o  out  5  destination.
  - id_rd_we_o  out  1  instruction writes rd (forced 0 when rd=0).
  - id_illegal_o  out  1  opcode/func3/func7 not RV32I.

## Operation
- **Register file:** NREGS=32 × XLEN.
  - x0 reads 0; writes to x0 are ignored.
  - The write occurs on the clk edge when wb_en_i=1.
- **Bypass:** a read of register r in the same cycle as wb_en_i with wb_rd_i=r (r≠0) returns wb_data_i.
- **Decode:** same instruction set and immediate formats as RV32I base.
  - rs1 used by: jalr, branch, load, store, op-imm, op.
  - rs2 used by: branch, store, op.
  - rd written by: lui, auipc, jal, jalr, load, op-imm, op.
  - Illegal encodings give imm_type=7, id_illegal_o=1, rd_we=0, and no source use.
- **Scoreboard:** cnt[r] is SB_W bits.
  - +1 on output handshake (id_valid_o && id_ready_i && id_rd_we_o) for id_rd_o.
  - −1 on wb_en_i for wb_rd_i≠0 when cnt>0; a wb_en_i at cnt=0 leaves cnt at 0.
  - Simultaneous +1 and −1 on the same register leaves cnt unchanged.
  - cnt[0] is always 0.
- **Hazard:** the hazard signal is 1 when, for any used source s≠0, either condition holds:
  - cnt[s]−(wb_en_i && wb_rd_i==s) > 0;
  - or id_valid_o && id_rd_we_o && id_rd_o==s (held or departing producer).
- **Saturation:** a stall also occurs when the fetched instruction has rd_we and cnt[rd]==2^SB_W−1.
- **Accept condition:** if_ready_o = !hazard && !sat && (!id_valid_o || id_ready_i) && !flush_i. Acceptance occurs when if_valid_i && if_ready_o.
- **Flush:** flush_i clears id_valid_o at the next edge, even if id_ready_i=1. It does not touch the scoreboard or register file.
- **Downstream contract:** every accepted instruction with rd_we=1 produces exactly one wb_en_i with that rd, including instructions later squashed.

## Timing
- **Reset:** while rst=1, all of the following are 0 / all-zero:
  - id_valid_o and every id_* data output;
  - all registers;
  - all cnt.
  if_ready_o follows its equation with id_valid_o=0. Reset mid-operation drops any held instruction with no handshake.
- **Latency:** accept at edge N → id_valid_o=1 after edge N; outputs remain stable until the handshake or flush.
- **Throughput:** 1 instruction per cycle when there is no hazard and id_ready_i=1.
- **Writeback-to-dependent issue:**
  - the dependent is accepted in the same cycle as the last matching wb_en_i, with the operand bypassed;
  - the counter update and RF write are visible from the next cycle.
- **Back-to-back dependency:** a dependent directly behind its producer stalls at least until that producer's writeback cycle.
- **Backpressure:** with id_valid_o=1 and id_ready_i=0, all id_* outputs stay stable.

## Test plan
- **Reset and fill:** rst, then addi x1,x0,5 (0x00500093).
  - id_valid_o after 1 cycle, id_imm_o=5, imm_type=1, rd=1, rd_we=1.
  - After the handshake, cnt[1]=1.
- **RAW stall and bypass:** addi x1,x0,5 then add x2,x1,x1.
  - if_ready_o=0 until wb_en_i (rd=1, data=5).
  - add is accepted in that cycle with rs1=rs2=5.
- **x0 handling:** wb to x0 with data 0xDEADBEEF.
  - A later read of x0 returns 0.
  - lui x0 gives rd_we=0 and no stall.
- **Saturation:** SB_W=2, issue 3 writers to x3 with no writeback.
  - A 4th writer stalls.
  - One wb to x3 releases it the next cycle.
- **Flush and backpressure:** hold id_ready_i=0 for 3 cycles, then assert flush_i.
  - Outputs stay constant during the hold.
  - After the flush, id_valid_o=0 and cnt is unchanged.
- **Illegal encoding:** instruction 0xFFFFFFFF.
  - id_illegal_o=1, imm_type=7, rd_we=0, and no stall on sources.
